// File: rtl/elbeth_wb_arbiter_if.sv
// Write-back arbiter bus: ALU and memory result streams in, register-file write port out.
// The arbiter uses the slave modport; the producer/observer side uses master.
interface elbeth_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd_addr;
    logic [31:0]   alu_rd_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic [4:0]    rd_addr;
    logic [31:0]   rd_data;
    logic          ctrl_w_enable;
    logic [CW-1:0] wb_pending;

    modport slave (
        input  alu_valid, alu_rd_addr, alu_rd_data,
        input  mem_valid, mem_rd_addr, mem_rd_data,
        output alu_ready, mem_ready,
        output rd_addr, rd_data, ctrl_w_enable, wb_pending
    );

    modport master (
        output alu_valid, alu_rd_addr, alu_rd_data,
        output mem_valid, mem_rd_addr, mem_rd_data,
        input  alu_ready, mem_ready,
        input  rd_addr, rd_data, ctrl_w_enable, wb_pending
    );
endinterface

// File: rtl/elbeth_wb_arbiter.sv
// Merges the single-cycle ALU result and FIFO-buffered memory results into one registered
// register-file write per cycle; a starvation counter forces a waiting memory result through.
module elbeth_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    elbeth_wb_arbiter_if.slave    bus
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int AGEW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_COUNT  = CW'(1);
    localparam logic [AW-1:0]   ONE_PTR    = AW'(1);
    localparam logic [AGEW-1:0] AGE_MAX    = AGEW'(STARVE_MAX);
    localparam logic [AGEW-1:0] ONE_AGE    = AGEW'(1);

    logic [4:0]      fifo_addr_r [DEPTH];
    logic [31:0]     fifo_data_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [AGEW-1:0] age_r;
    logic [4:0]      rd_addr_r;
    logic [31:0]     rd_data_r;
    logic            we_r;

    logic full_s;
    logic nonempty_s;
    logic force_s;
    logic alu_xfer_s;
    logic mem_grant_s;
    logic push_s;

    // Arbitration decision, derived only from registered state and the ALU offer.
    always_comb begin
        full_s      = (count_r == FULL_COUNT);
        nonempty_s  = (count_r != {CW{1'b0}});
        force_s     = nonempty_s && (full_s || (age_r >= AGE_MAX));
        alu_xfer_s  = bus.alu_valid && !force_s;
        mem_grant_s = nonempty_s && !alu_xfer_s;
        push_s      = bus.mem_valid && !full_s;
    end

    assign bus.alu_ready     = !force_s;
    assign bus.mem_ready     = !full_s;
    assign bus.rd_addr       = rd_addr_r;
    assign bus.rd_data       = rd_data_r;
    assign bus.ctrl_w_enable = we_r;
    assign bus.wb_pending    = count_r;

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.mem_rd_addr;
            fifo_data_r[wr_ptr_r] <= bus.mem_rd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (mem_grant_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, mem_grant_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Counts edges on which the FIFO head was passed over; saturates at the force threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_r <= {AGEW{1'b0}};
        end else if (mem_grant_s || !nonempty_s) begin
            age_r <= {AGEW{1'b0}};
        end else if (age_r < AGE_MAX) begin
            age_r <= age_r + ONE_AGE;
        end else begin
            age_r <= age_r;
        end
    end

    // Register-file write port; x0 targets are consumed but never enable a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r <= 5'd0;
            rd_data_r <= 32'd0;
            we_r      <= 1'b0;
        end else if (alu_xfer_s) begin
            rd_addr_r <= bus.alu_rd_addr;
            rd_data_r <= bus.alu_rd_data;
            we_r      <= (bus.alu_rd_addr != 5'd0);
        end else if (mem_grant_s) begin
            rd_addr_r <= fifo_addr_r[rd_ptr_r];
            rd_data_r <= fifo_data_r[rd_ptr_r];
            we_r      <= (fifo_addr_r[rd_ptr_r] != 5'd0);
        end else begin
            we_r      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_elbeth_wb_arbiter.sv
// Directed, table-driven bench for elbeth_wb_arbiter (DEPTH=4, STARVE_MAX=3),
// plus a hand-written starvation sequence with a bounded wait.
module tb_elbeth_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    elbeth_wb_arbiter_if #(.DEPTH(4)) bus ();

    elbeth_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_pend;
        logic        e_ardy;
        logic        e_mrdy;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic av, input logic [4:0] aa,
                                input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                                input logic [31:0] md, input logic e_we, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic [2:0] e_pend,
                                input logic e_ardy, input logic e_mrdy);
        vec_t v;
        v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_pend = e_pend;
        v.e_ardy = e_ardy; v.e_mrdy = e_mrdy;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        rst             = r;
        bus.alu_valid   = av;
        bus.alu_rd_addr = aa;
        bus.alu_rd_data = ad;
        bus.mem_valid   = mv;
        bus.mem_rd_addr = ma;
        bus.mem_rd_data = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // reset held with both streams offering
        add(1, 1, 5'd3,  32'h11, 1, 5'd9,  32'h22, 0, 5'd0,  32'h0,        3'd0, 1, 1);
        add(1, 1, 5'd3,  32'h11, 1, 5'd9,  32'h22, 0, 5'd0,  32'h0,        3'd0, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        3'd0, 1, 1);
        // single ALU write, idle hold, x0 write suppressed
        add(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 3'd0, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd5,  32'hDEADBEEF, 3'd0, 1, 1);
        add(0, 1, 5'd0,  32'hCAFEF00D, 0, 5'd0, 32'h0, 0, 5'd0, 32'hCAFEF00D, 3'd0, 1, 1);
        // single memory push, written one edge later
        add(0, 0, 5'd0,  32'h0,  1, 5'd7,  32'h12345678, 0, 5'd0, 32'hCAFEF00D, 3'd1, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  1, 5'd7,  32'h12345678, 3'd0, 1, 1);
        // starvation: push under continuous ALU traffic
        add(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 1, 5'd10, 32'hA0, 3'd1, 1, 1);
        add(0, 1, 5'd12, 32'hA1, 0, 5'd0,  32'h0,  1, 5'd12, 32'hA1, 3'd1, 1, 1);
        add(0, 1, 5'd13, 32'hA2, 0, 5'd0,  32'h0,  1, 5'd13, 32'hA2, 3'd1, 1, 1);
        add(0, 1, 5'd14, 32'hA3, 0, 5'd0,  32'h0,  1, 5'd14, 32'hA3, 3'd1, 0, 1);
        add(0, 1, 5'd15, 32'hA4, 0, 5'd0,  32'h0,  1, 5'd11, 32'hB0, 3'd0, 1, 1);
        add(0, 1, 5'd15, 32'hA4, 0, 5'd0,  32'h0,  1, 5'd15, 32'hA4, 3'd0, 1, 1);
        // fill to full, forced pop, no push while full, drain in order
        add(0, 1, 5'd16, 32'hA5, 1, 5'd1,  32'hC1, 1, 5'd16, 32'hA5, 3'd1, 1, 1);
        add(0, 1, 5'd17, 32'hA6, 1, 5'd2,  32'hC2, 1, 5'd17, 32'hA6, 3'd2, 1, 1);
        add(0, 1, 5'd18, 32'hA7, 1, 5'd3,  32'hC3, 1, 5'd18, 32'hA7, 3'd3, 1, 1);
        add(0, 1, 5'd19, 32'hA8, 1, 5'd4,  32'hC4, 1, 5'd19, 32'hA8, 3'd4, 0, 0);
        add(0, 1, 5'd20, 32'hA9, 1, 5'd5,  32'hC5, 1, 5'd1,  32'hC1, 3'd3, 1, 1);
        add(0, 1, 5'd20, 32'hA9, 0, 5'd0,  32'h0,  1, 5'd20, 32'hA9, 3'd3, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  1, 5'd2,  32'hC2, 3'd2, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  1, 5'd3,  32'hC3, 3'd1, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  1, 5'd4,  32'hC4, 3'd0, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd4,  32'hC4, 3'd0, 1, 1);
        // three pending then reset: entries discarded
        add(0, 1, 5'd21, 32'hB1, 1, 5'd6,  32'hD1, 1, 5'd21, 32'hB1, 3'd1, 1, 1);
        add(0, 1, 5'd22, 32'hB2, 1, 5'd7,  32'hD2, 1, 5'd22, 32'hB2, 3'd2, 1, 1);
        add(0, 1, 5'd23, 32'hB3, 1, 5'd8,  32'hD3, 1, 5'd23, 32'hB3, 3'd3, 1, 1);
        add(1, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        3'd0, 1, 1);
        // simultaneous push and pop keeps occupancy
        add(0, 0, 5'd0,  32'h0,  1, 5'd9,  32'hE1, 0, 5'd0,  32'h0,        3'd1, 1, 1);
        add(0, 0, 5'd0,  32'h0,  1, 5'd10, 32'hE2, 1, 5'd9,  32'hE1,       3'd1, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  1, 5'd10, 32'hE2,       3'd0, 1, 1);
        add(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 5'd10, 32'hE2,       3'd0, 1, 1);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].av, vq[i].aa, vq[i].ad, vq[i].mv, vq[i].ma, vq[i].md);
            step();
            chk($sformatf("v%0d.we", i),    {31'd0, bus.ctrl_w_enable}, {31'd0, vq[i].e_we});
            chk($sformatf("v%0d.addr", i),  {27'd0, bus.rd_addr},       {27'd0, vq[i].e_addr});
            chk($sformatf("v%0d.data", i),  bus.rd_data,                vq[i].e_data);
            chk($sformatf("v%0d.pend", i),  {29'd0, bus.wb_pending},    {29'd0, vq[i].e_pend});
            chk($sformatf("v%0d.ardy", i),  {31'd0, bus.alu_ready},     {31'd0, vq[i].e_ardy});
            chk($sformatf("v%0d.mrdy", i),  {31'd0, bus.mem_ready},     {31'd0, vq[i].e_mrdy});
        end

        // starvation under a held alu_valid: count ALU-ready cycles after the push, bounded
        drive(1'b0, 1'b1, 5'd30, 32'h300, 1'b1, 5'd31, 32'hF00D);
        step();
        drive(1'b0, 1'b1, 5'd30, 32'h301, 1'b0, 5'd0, 32'h0);
        n = 0;
        while (bus.alu_ready && n < 10) begin
            n++;
            step();
        end
        chk("starve.ready_cycles", n, 32'd3);
        step();
        chk("starve.mem_we",   {31'd0, bus.ctrl_w_enable}, 32'd1);
        chk("starve.mem_addr", {27'd0, bus.rd_addr},       32'd31);
        chk("starve.mem_data", bus.rd_data,                32'hF00D);
        chk("starve.ardy_back", {31'd0, bus.alu_ready},    32'd1);
        step();
        chk("starve.alu_addr", {27'd0, bus.rd_addr},       32'd30);
        chk("starve.pend",     {29'd0, bus.wb_pending},    32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("end.we", {31'd0, bus.ctrl_w_enable}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elbeth_wb_arbiter.md
Name: elbeth_wb_arbiter

Overview:
Write-back arbiter that drives the single write port of the ELBETH general-purpose register file. It merges two result streams into one registered write per cycle: the single-cycle ALU result and the long-latency memory/load result. The memory path is buffered in a small FIFO, and a starvation counter bounds how long a buffered result can wait behind ALU traffic. Its outputs connect directly to the register file's rd_addr, rd_data and ctrl_w_enable inputs.

Parameters:
DEPTH, 4, memory-result FIFO entries (power of 2, >= 2)
STARVE_MAX, 3, cycles a FIFO head may be passed over before it is forced through (>= 1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
alu_rd_addr  in  5  ALU destination register
alu_rd_data  in  32  ALU result
mem_valid  in  1  memory result offered
mem_ready  out  1  FIFO can accept a memory result
mem_rd_addr  in  5  memory destination register
mem_rd_data  in  32  memory result
rd_addr  out  5  register-file write address
rd_data  out  32  register-file write data
ctrl_w_enable  out  1  register-file write enable
wb_pending  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): clears FIFO pointers, FIFO count, age counter, ctrl_w_enable, rd_addr and rd_data to 0. After reset: alu_ready=1, mem_ready=1, wb_pending=0. Reset mid-operation discards all pending entries; no write is issued for them.
- Memory push: occurs on a rising edge when mem_valid && mem_ready.
  - mem_ready = !full, from registered state only.
  - No same-cycle pass-through and no push while full, even if a pop occurs in the same cycle.
- Arbitration (combinational from current state):
  - force = nonempty && (full || age >= STARVE_MAX).
  - alu_ready = !force. alu_ready has no combinational path from alu_valid.
  - alu_xfer = alu_valid && alu_ready.
  - mem_grant = nonempty && !alu_xfer.
- Output register, updated on each rising edge:
  - If alu_xfer: rd_addr<=alu_rd_addr, rd_data<=alu_rd_data, ctrl_w_enable<=(alu_rd_addr!=0).
  - Else if mem_grant: load the FIFO head the same way, then pop.
  - Else: ctrl_w_enable<=0; rd_addr and rd_data hold their values.
- Writes to x0: a result with address 0 still consumes its transfer and FIFO slot, but produces ctrl_w_enable=0.
- Latency:
  - ALU accepted at edge N -> write asserted from edge N.
  - Memory result pushed at edge N -> earliest write asserted from edge N+1.
- Age counter:
  - Increments on each edge where nonempty && !mem_grant, saturating at STARVE_MAX.
  - Clears to 0 on pop and while the FIFO is empty.
- Ordering: memory results are written in push order. There is no ordering guarantee between the ALU and memory streams; issue logic guarantees no WAW conflict between the two streams.
- Simultaneous push and pop: allowed when not full; count unchanged, wb_pending unchanged.
- Pointers wrap modulo DEPTH. wb_pending equals the registered count.
- Timing contract: outputs change on the rising edge. The register file captures on the following falling edge, so a written value is readable in the second half of the same cycle.

Test Plan:
1. Hold rst=1 for 2 cycles with mem_valid=1 and alu_valid=1 -> ctrl_w_enable=0, wb_pending=0, no writes issued. After release, alu_ready=1 and mem_ready=1.
2. Single ALU pulse, addr 5, data 0xDEADBEEF -> after the next edge, ctrl_w_enable=1, rd_addr=5, rd_data=0xDEADBEEF. Following idle cycle -> ctrl_w_enable=0 with rd_addr and rd_data held. ALU addr 0 -> ctrl_w_enable=0.
3. Single memory push, addr 7, data 0x12345678, at edge N with ALU idle -> wb_pending=1 after edge N. Write of 7/0x12345678 after edge N+1; wb_pending=0.
4. STARVE_MAX=3, alu_valid held high, one memory push -> ALU writes for 3 cycles, then alu_ready=0 for exactly one cycle and the memory write occurs. alu_ready returns to 1 on the next cycle.
5. DEPTH=4, alu_valid high, pushes to addrs 1,2,3,4 -> mem_ready=0 at wb_pending=4. One forced pop writes addr 1, then mem_ready=1. Remaining entries drain in order 2,3,4.
6. With 3 entries pending, assert rst for 1 cycle -> wb_pending=0, and none of the 3 entries is ever written.
